clock_ctrl: RTL and testbench

Timekeeping and set-mode controller for the four-digit seven-segment clock. Derives seconds from the system clock and maintains a 12-hour HH:MM time. Handles two debounced pushbuttons (mode, up) for setting hours and minutes. Drives the display multiplexer's 12-bit time bus and decimal-point input.

---
 rtl/clock_pkg.sv | 44 ++++
 rtl/clock_ctrl_btn_sync_edge.sv | 32 +++
 rtl/clock_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_clock_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared state type, digit limits and reset time for the clock_ctrl timekeeping slice.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    localparam logic [3:0] HOUR_MIN = 4'd1;
    localparam logic [3:0] HOUR_MAX = 4'd12;
    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_MAX  = 4'd9;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    localparam logic [3:0] RST_HOUR = 4'd12;
    localparam logic [3:0] RST_TENS = 4'd0;
    localparam logic [3:0] RST_MIN  = 4'd0;

    function automatic logic [3:0] next_hour(input logic [3:0] hour);
        return (hour == HOUR_MAX) ? HOUR_MIN : hour + 4'd1;
    endfunction

    // Advances the BCD minute pair 00..59; bit 8 of the result flags the 59->00 wrap.
    function automatic logic [8:0] next_minutes(input logic [3:0] tens, input logic [3:0] units);
        logic       carry;
        logic [3:0] tens_n;
        logic [3:0] units_n;
        carry   = 1'b0;
        tens_n  = tens;
        units_n = units + 4'd1;
        if (units == MIN_MAX) begin
            units_n = '0;
            if (tens == TENS_MAX) begin
                tens_n = '0;
                carry  = 1'b1;
            end else begin
                tens_n = tens + 4'd1;
            end
        end
        return {carry, tens_n, units_n};
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for a debounced button, with a registered one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/clock_ctrl.sv
// 12-hour HH:MM timekeeper with mode/up set buttons for the seven-segment clock.
// Optional AUTO_REPEAT_EN adds hold-to-repeat on the up button in the set states.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned SYS_FREQ      = 100_000_000,
    parameter int unsigned REPEAT_DELAY  = SYS_FREQ / 2,
    parameter int unsigned REPEAT_PERIOD = SYS_FREQ / 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    output logic [11:0] time_bus,
    output logic        dp,
    output logic        set_hr,
    output logic        set_min
);

    localparam int unsigned HALF = SYS_FREQ / 2;
    localparam int unsigned PW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF - 1);

    state_e        state_q, state_d;
    logic [3:0]    hour_q, hour_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          blink_q, blink_d;
    logic          dp_q, dp_d;
    logic          set_hr_q, set_min_q;

    logic          mode_level, mode_rise;
    logic          up_level, up_rise;
    logic          up_inc;
    logic          half_tick, sec_tick;
    logic [8:0]    min_next;

    btn_sync_edge u_mode_sync (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (btn_mode),
        .level_o (mode_level),
        .rise_o  (mode_rise)
    );

    btn_sync_edge u_up_sync (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (btn_up),
        .level_o (up_level),
        .rise_o  (up_rise)
    );

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_fire;
    logic          unused_level;

    assign unused_level = mode_level;
    assign rpt_fire     = up_level && (rpt_cnt_q == RW'(REPEAT_DELAY));
    assign up_inc       = up_rise | rpt_fire;

    // Counter tracks cycles the synchronised level has been high; after the first
    // fire it reloads so each later fire lands exactly REPEAT_PERIOD cycles apart.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
        if (state_q == RUN || !up_level || mode_rise) begin
            rpt_cnt_d = '0;
        end else if (rpt_fire) begin
            rpt_cnt_d = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    localparam logic unused_rpt_cfg = (REPEAT_PERIOD <= REPEAT_DELAY);
    logic unused_level;

    assign unused_level = mode_level ^ up_level;
    assign up_inc       = up_rise;
`endif

    assign half_tick = (presc_q == PRESC_LAST);
    assign sec_tick  = half_tick & blink_q;
    assign min_next  = next_minutes(tens_q, min_q);

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        tens_d  = tens_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = half_tick ? '0 : presc_q + PW'(1);
        blink_d = blink_q ^ half_tick;

        case (state_q)
            RUN: begin
                // Any minute carry is applied before a same-cycle mode change takes effect.
                if (sec_tick) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d  = '0;
                        tens_d = min_next[7:4];
                        min_d  = min_next[3:0];
                        if (min_next[8]) begin
                            hour_d = next_hour(hour_q);
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                if (mode_rise) begin
                    state_d = SET_HR;
                    sec_d   = '0;
                end
            end
            SET_HR: begin
                sec_d = '0;
                if (mode_rise) begin
                    state_d = SET_MIN;
                end else if (up_inc) begin
                    hour_d = next_hour(hour_q);
                end
            end
            SET_MIN: begin
                sec_d = '0;
                if (mode_rise) begin
                    // Restart the second phase so the first minute after setting is a full 60 s.
                    state_d = RUN;
                    presc_d = '0;
                    blink_d = 1'b0;
                end else if (up_inc) begin
                    tens_d = min_next[7:4];
                    min_d  = min_next[3:0];
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        dp_d = (state_d == SET_HR) | ((state_d == RUN) & blink_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            hour_q    <= RST_HOUR;
            tens_q    <= RST_TENS;
            min_q     <= RST_MIN;
            sec_q     <= '0;
            presc_q   <= '0;
            blink_q   <= 1'b0;
            dp_q      <= 1'b0;
            set_hr_q  <= 1'b0;
            set_min_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            tens_q    <= tens_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            dp_q      <= dp_d;
            set_hr_q  <= (state_d == SET_HR);
            set_min_q <= (state_d == SET_MIN);
        end
    end

    assign time_bus = {hour_q, tens_q, min_q};
    assign dp       = dp_q;
    assign set_hr   = set_hr_q;
    assign set_min  = set_min_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus pushes expected outputs per cycle, a monitor pops and compares.
// Time is modelled as a minute index 0..719 (0 = 12:00); AUTO_REPEAT_EN selects the repeat expectation.
module tb_clock_ctrl;

    localparam int unsigned SYS_FREQ      = 10;
    localparam int unsigned REPEAT_DELAY  = 20;
    localparam int unsigned REPEAT_PERIOD = 4;
    localparam int unsigned CPM           = SYS_FREQ * 60;
    localparam int unsigned HALF          = SYS_FREQ / 2;

    localparam int unsigned K_RESET  = 0;
    localparam int unsigned K_RUN    = 1;
    localparam int unsigned K_PRE    = 2;
    localparam int unsigned K_POST   = 3;
    localparam int unsigned K_REPEAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic [11:0] time_bus;
    logic        dp;
    logic        set_hr;
    logic        set_min;

    clock_ctrl #(
        .SYS_FREQ      (SYS_FREQ),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .time_bus (time_bus),
        .dp       (dp),
        .set_hr   (set_hr),
        .set_min  (set_min)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        int unsigned kind;
        logic [11:0] tbus;
        logic        dp;
        logic        sh;
        logic        sm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: 0 = run, 1 = set hour, 2 = set minute.
    int unsigned m_state = 0;
    int unsigned m_t = 0;
    int unsigned run_start = 0;

    function automatic string kname(input int unsigned k);
        case (k)
            K_RESET:  return "reset";
            K_RUN:    return "run";
            K_PRE:    return "pre_edge";
            K_POST:   return "post_edge";
            K_REPEAT: return "repeat_hold";
            default:  return "other";
        endcase
    endfunction

    function automatic logic [11:0] bcd(input int unsigned t);
        int unsigned h;
        int unsigned m;
        h = t / 60;
        if (h == 0) h = 12;
        m = t % 60;
        return {h[3:0], 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic exp_t model_at(input int unsigned c, input int unsigned kind);
        exp_t e;
        int unsigned n;
        e.due  = c;
        e.kind = kind;
        e.sh   = (m_state == 1);
        e.sm   = (m_state == 2);
        if (m_state == 0) begin
            n      = c - run_start;
            e.tbus = bcd((m_t + n / CPM) % 720);
            e.dp   = ((n / HALF) % 2) == 1;
        end else begin
            e.tbus = bcd(m_t);
            e.dp   = (m_state == 1);
        end
        return e;
    endfunction

    function automatic int unsigned rh();
        return $urandom_range(1, 4);
    endfunction

    task automatic push(input int unsigned c, input int unsigned kind);
        sb.push_back(model_at(c, kind));
    endtask

    task automatic push_reset(input int unsigned c);
        exp_t e;
        e.due  = c;
        e.kind = K_RESET;
        e.tbus = 12'hC00;
        e.dp   = 1'b0;
        e.sh   = 1'b0;
        e.sm   = 1'b0;
        sb.push_back(e);
    endtask

    task automatic apply(input bit pm, input bit pu, input int unsigned ev);
        if (pm) begin
            case (m_state)
                0: begin
                    m_t     = (m_t + (ev - run_start) / CPM) % 720;
                    m_state = 1;
                end
                1: m_state = 2;
                default: begin
                    m_state   = 0;
                    run_start = ev;
                end
            endcase
        end else if (pu) begin
            if (m_state == 1) m_t = (((m_t / 60) + 1) % 12) * 60 + m_t % 60;
            else if (m_state == 2) m_t = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
        end
    endtask

    task automatic release_reset();
        rst       = 1'b1;
        run_start = cyc;
        m_state   = 0;
        m_t       = 0;
    endtask

    task automatic press(input bit pm, input bit pu, input int unsigned hold);
        int unsigned ev;
        @(negedge clk);
        btn_mode = pm;
        btn_up   = pu;
        ev = cyc + 4;
        push(ev - 1, K_PRE);
        apply(pm, pu, ev);
        push(ev, K_POST);
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        repeat ($urandom_range(3, 6)) @(negedge clk);
    endtask

    task automatic hold_up(input int unsigned n);
        int unsigned d;
        int unsigned incs;
        @(negedge clk);
        btn_up = 1'b1;
        d = cyc;
        push(d + 3, K_PRE);
        incs = 1;
`ifdef AUTO_REPEAT_EN
        if (m_state != 0 && n - 1 >= REPEAT_DELAY)
            incs += 1 + (n - 1 - REPEAT_DELAY) / REPEAT_PERIOD;
`endif
        repeat (incs) apply(1'b0, 1'b1, d + 4);
        push(d + n + 8, K_REPEAT);
        repeat (n) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_cycles(input int unsigned n);
        int unsigned s;
        int unsigned b;
        int unsigned due[$];
        s = cyc;
        for (int unsigned i = 1; i <= 12 && i <= n; i++) due.push_back(s + i);
        for (int k = 0; k < 4; k++) due.push_back(s + $urandom_range(1, n));
        if (m_state == 0) begin
            b = run_start + CPM * ((s - run_start) / CPM + 1);
            if (b <= s + n) begin
                if (b - 1 > s) due.push_back(b - 1);
                due.push_back(b);
            end
        end
        due.sort();
        foreach (due[i]) push(due[i], K_RUN);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input int unsigned h, input int unsigned mi);
        press(1'b1, 1'b0, rh());
        while (m_t / 60 != h % 12) press(1'b0, 1'b1, rh());
        press(1'b1, 1'b0, rh());
        while (m_t % 60 != mi) press(1'b0, 1'b1, rh());
        press(1'b1, 1'b0, rh());
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
                failures++;
                $display("FAIL %s late: due cycle %0d, checked at %0d", kname(e.kind), e.due, cyc);
            end else if ({time_bus, dp, set_hr, set_min} !== {e.tbus, e.dp, e.sh, e.sm}) begin
                failures++;
                $display("FAIL %s cyc=%0d got time=%h dp=%b set_hr=%b set_min=%b, expected time=%h dp=%b set_hr=%b set_min=%b",
                         kname(e.kind), cyc, time_bus, dp, set_hr, set_min, e.tbus, e.dp, e.sh, e.sm);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        push_reset(cyc + 1);
        repeat (2) @(negedge clk);
        release_reset();
        run_cycles(600);

        run_cycles($urandom_range(1, 300));
        set_time(12, 59);
        run_cycles(600);

        run_cycles($urandom_range(1, 300));
        set_time(9, 59);
        run_cycles(600);

        run_cycles($urandom_range(1, 300));
        set_time(12, 59);
        set_time(1, 0);
        run_cycles(600);

        // Mode and up rising together in SET_HR: mode wins, hour untouched.
        press(1'b1, 1'b0, rh());
        press(1'b1, 1'b1, rh());
        press(1'b1, 1'b0, rh());
        run_cycles(30);

        press(1'b1, 1'b0, rh());
        press(1'b1, 1'b0, rh());
        hold_up(40);
        press(1'b1, 1'b0, rh());
        run_cycles(20);

        // Asynchronous reset while in SET_MIN, asserted between clock edges.
        press(1'b1, 1'b0, rh());
        press(1'b1, 1'b0, rh());
        press(1'b0, 1'b1, rh());
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_reset(cyc);
        repeat (3) @(negedge clk);
        push_reset(cyc + 1);
        @(negedge clk);
        release_reset();
        run_cycles(620);

        for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
